// File: rtl/pulse_spacer.sv
// Source-domain pacer that queues event pulses and re-emits them at least MIN_GAP cycles apart.
// Optional sticky drop status is enabled by defining PULSE_SPACER_OVF_STATUS_EN.
module pulse_spacer #(
  parameter int MIN_GAP   = 6,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 PULSE_IN,
`ifdef PULSE_SPACER_OVF_STATUS_EN
  input  logic                 OVF_CLR,
  output logic                 OVERFLOW,
`endif
  output logic                 PULSE_OUT,
  output logic [CNT_WIDTH-1:0] PENDING,
  output logic                 BUSY
);

  localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  generate
    if (MIN_GAP < 2 || CNT_WIDTH < 1) begin : g_bad_params
      $fatal(1, "pulse_spacer: MIN_GAP must be >= 2 and CNT_WIDTH >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, GAP} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;

  logic has_backlog;
  logic fire;
  logic inc;
  logic dec;
  logic drop;

  // A fresh event fires straight through only when nothing is queued ahead of it.
  assign has_backlog = (PENDING != '0);
  assign fire        = (state == IDLE) && (has_backlog || PULSE_IN);
  assign dec         = (state == IDLE) && has_backlog;
  assign inc         = PULSE_IN && !(fire && !has_backlog);
  assign drop        = inc && !dec && (PENDING == CNT_MAX);
  assign BUSY        = (state == GAP) || has_backlog;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      PULSE_OUT <= 1'b0;
      PENDING   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            PULSE_OUT <= 1'b1;
            state     <= GAP;
            gap_cnt   <= GAP_LOAD;
          end else begin
            PULSE_OUT <= 1'b0;
          end
        end
        GAP: begin
          PULSE_OUT <= 1'b0;
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          PULSE_OUT <= 1'b0;
          state     <= IDLE;
        end
      endcase

      // Saturating backlog: an arrival matched by a departure leaves the count unchanged.
      if (inc && !dec && !drop) begin
        PENDING <= PENDING + CNT_WIDTH'(1);
      end else if (dec && !inc) begin
        PENDING <= PENDING - CNT_WIDTH'(1);
      end
    end
  end

`ifdef PULSE_SPACER_OVF_STATUS_EN
  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      OVERFLOW <= 1'b0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
    end else if (OVF_CLR) begin
      OVERFLOW <= 1'b0;
    end
  end
`endif

endmodule
